// File: rtl/pll_lock_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pll_lock_ctrl
//
// Purpose:
//   Sequences the reset and lock acquisition of an external PLL from the reference clock
//   alone. The PLL is held in reset for a fixed period and then given a bounded window to
//   report lock. Lock must stay stable for a programmable number of cycles before downstream
//   logic is released. Timed-out attempts are retried a limited number of times before the
//   controller parks in a terminal fail state. Loss of lock while running restarts the whole
//   sequence and raises a one-cycle notification.
//
// Parameters:
//   RST_CYCLES   - clkin cycles pll_reset is held high per attempt            (2..255)
//   LOCK_STABLE  - consecutive synchronized lock-high cycles before release   (2..65535)
//   LOCK_TIMEOUT - cycles allowed in WAIT_LOCK before an attempt is abandoned (2..65535)
//   MAX_RETRY    - failed attempts tolerated before FAIL                      (1..3)
//
// Ports:
//   i_clkin       in   1  reference clock; the only clock of this block
//   i_reset       in   1  synchronous active-high reset
//   i_pll_lock    in   1  PLL lock flag, asynchronous to i_clkin
//   o_pll_reset   out  1  PLL reset pin drive, active-high
//   o_sys_rst     out  1  synchronous active-high reset for downstream logic
//   o_ready       out  1  high while locked and released (RUN)
//   o_fail        out  1  high in FAIL
//   o_retry_cnt   out  2  failed attempts since the last RUN entry or reset
//   o_lock_lost   out  1  one-cycle pulse when lock drops in RUN
// ---------------------------------------------------------------------------------------------
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 27000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       i_clkin,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  output logic       o_pll_reset,
  output logic       o_sys_rst,
  output logic       o_ready,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt,
  output logic       o_lock_lost
);

  // -------------------------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // -------------------------------------------------------------------------------------------
  if (RST_CYCLES < 2 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("pll_lock_ctrl: RST_CYCLES out of range 2..255");
  end
  if (LOCK_STABLE < 2 || LOCK_STABLE > 65535) begin : g_bad_lock_stable
    $error("pll_lock_ctrl: LOCK_STABLE out of range 2..65535");
  end
  if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_bad_lock_timeout
    $error("pll_lock_ctrl: LOCK_TIMEOUT out of range 2..65535");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_max_retry
    $error("pll_lock_ctrl: MAX_RETRY out of range 1..3");
  end

  // Terminal counts, pre-cast to the counter width so every compare is width-matched.
  localparam logic [15:0] RstLast     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] StableLast  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]  RetryMax    = 2'(MAX_RETRY);
  localparam logic [15:0] CntMax      = 16'hFFFF;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } t_state;

  // -------------------------------------------------------------------------------------------
  // Lock synchronizer: only r_lock_s is ever used by the control logic.
  // -------------------------------------------------------------------------------------------
  logic r_lock_meta;
  logic r_lock_s;

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // -------------------------------------------------------------------------------------------
  // State, shared counter and retry counter
  // -------------------------------------------------------------------------------------------
  t_state      r_state;
  t_state      w_state_d;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_d;
  logic [1:0]  r_retry;
  logic [1:0]  w_retry_d;
  logic [1:0]  w_retry_inc;

  assign w_retry_inc = r_retry + 2'd1;

  always_comb begin
    w_state_d = r_state;
    w_retry_d = r_retry;
    unique case (r_state)
      StResetPll: begin
        if (r_cnt == RstLast) begin
          w_state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        // Lock is tested first so that it wins over a coincident timeout.
        if (r_lock_s) begin
          w_state_d = StStable;
        end else if (r_cnt == TimeoutLast) begin
          w_retry_d = w_retry_inc;
          if (w_retry_inc >= RetryMax) begin
            w_state_d = StFail;
          end else begin
            w_state_d = StResetPll;
          end
        end
      end
      StStable: begin
        // Any low sample aborts; the PLL is not reset, only the timeout window restarts.
        if (!r_lock_s) begin
          w_state_d = StWaitLock;
        end else if (r_cnt == StableLast) begin
          w_state_d = StRun;
          w_retry_d = 2'd0;
        end
      end
      StRun: begin
        if (!r_lock_s) begin
          w_state_d = StResetPll;
        end
      end
      StFail: begin
        w_state_d = StFail;
      end
      default: begin
        w_state_d = StResetPll;
      end
    endcase
  end

  // Counter restarts on every state change and saturates rather than wrapping.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = 16'd0;
    end else if (r_cnt != CntMax) begin
      w_cnt_d = r_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state <= StResetPll;
      r_cnt   <= 16'd0;
      r_retry <= 2'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_retry <= w_retry_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Registered outputs. They are decoded from the next state so that each output register
  // always holds the decode of the state register it is updated alongside; no extra cycle of
  // lag is added between a state change and its outputs.
  // -------------------------------------------------------------------------------------------
  logic r_pll_reset;
  logic r_sys_rst;
  logic r_ready;
  logic r_fail;
  logic r_lock_lost;

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_d == StResetPll) || (w_state_d == StFail);
      r_sys_rst   <= (w_state_d != StRun);
      r_ready     <= (w_state_d == StRun);
      r_fail      <= (w_state_d == StFail);
      // High only for the first RESET_PLL cycle after leaving RUN.
      r_lock_lost <= (r_state == StRun) && (w_state_d == StResetPll);
    end
  end

  assign o_pll_reset = r_pll_reset;
  assign o_sys_rst   = r_sys_rst;
  assign o_ready     = r_ready;
  assign o_fail      = r_fail;
  assign o_lock_lost = r_lock_lost;
  assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32,
// MAX_RETRY=3. Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "edge Ek" below means the k-th rising edge after the last edge at which reset was sampled.
// ---------------------------------------------------------------------------------------------
module tb_pll_lock_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic       lock_lost;

  int n_checks;
  int n_errors;

  pll_lock_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (3)
  ) u_dut (
    .i_clkin    (clk),
    .i_reset    (rst),
    .i_pll_lock (pll_lock),
    .o_pll_reset(pll_reset),
    .o_sys_rst  (sys_rst),
    .o_ready    (ready),
    .o_fail     (fail),
    .o_retry_cnt(retry_cnt),
    .o_lock_lost(lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Reset is sampled at three edges; on return we sit just after E0 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) next_edge();
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------------------------
  task automatic test_reset();
    pll_lock = 1'b0;
    do_reset();
    n_checks++;
    if ({pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt} !== 7'b1100000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required %b",
               {pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt}, 7'b1100000);
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // pll_reset high 4 samples (E0..E3); lock raised after E10; ready after E21 (11 edges).
  task automatic test_normal_start();
    int  n_hi;
    int  n;
    bit  seen;
    pll_lock = 1'b0;
    do_reset();
    n_hi = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) next_edge();
      if (pll_reset) n_hi++;
    end
    n_checks++;
    if (n_hi !== 4) begin
      n_errors++;
      $display("FAIL normal_pll_reset_width: got %0d cycles required 4", n_hi);
    end
    pll_lock = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      next_edge();
      n++;
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 11) begin
      n_errors++;
      $display("FAIL normal_ready_latency: got %0d (seen=%0d) required 11", n, seen);
    end
    n_checks++;
    if ({sys_rst, pll_reset, retry_cnt} !== 4'b0000) begin
      n_errors++;
      $display("FAIL normal_run_outputs: got %b required 0000", {sys_rst, pll_reset, retry_cnt});
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // Lock high after E10..E15, low after E15, high again after E16. STABLE aborts, so ready
  // needs a fresh 8-cycle window: first high 11 edges after E16.
  task automatic test_flaky();
    int n;
    bit seen;
    pll_lock = 1'b0;
    do_reset();
    repeat (10) next_edge();
    pll_lock = 1'b1;
    repeat (5) next_edge();
    pll_lock = 1'b0;
    next_edge();
    pll_lock = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_edge();
      n++;
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 11) begin
      n_errors++;
      $display("FAIL flaky_ready_latency: got %0d (seen=%0d) required 11", n, seen);
    end
    n_checks++;
    if (retry_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL flaky_retry_cnt: got %0d required 0", retry_cnt);
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // Entered in RUN. Drop after F0: two synchronizer edges plus the transition edge -> pulse
  // after F3. Relock raised after F4: RESET_PLL F3..F6, WAIT F7, STABLE F8..F15, RUN F16.
  task automatic test_loss_in_run();
    int n;
    bit seen;
    pll_lock = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      next_edge();
      n++;
      if (lock_lost) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 3) begin
      n_errors++;
      $display("FAIL loss_pulse_latency: got %0d (seen=%0d) required 3", n, seen);
    end
    n_checks++;
    if ({ready, sys_rst, pll_reset} !== 3'b011) begin
      n_errors++;
      $display("FAIL loss_outputs: got %b required 011", {ready, sys_rst, pll_reset});
    end
    next_edge();
    n_checks++;
    if (lock_lost !== 1'b0) begin
      n_errors++;
      $display("FAIL loss_pulse_width: got %b required 0", lock_lost);
    end
    pll_lock = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_edge();
      n++;
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 12 || retry_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL loss_relock: got %0d edges retry %0d (seen=%0d) required 12 edges retry 0",
               n, retry_cnt, seen);
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // WAIT_LOCK holds cnt 0..31 over E4..E35. Lock raised after E33 is synchronized at E35, in
  // time for cnt==31: STABLE at E36, RUN at E44. Raised after E34 it is one cycle late: timeout
  // at E36 (retry 1), retry from RESET_PLL E36..E39, WAIT E40, STABLE E41, RUN E49.
  task automatic test_boundary();
    int n;
    bit seen;
    pll_lock = 1'b0;
    do_reset();
    repeat (33) next_edge();
    pll_lock = 1'b1;
    repeat (3) next_edge();
    n_checks++;
    if ({pll_reset, retry_cnt} !== 3'b000) begin
      n_errors++;
      $display("FAIL boundary_lock_wins: got pll_reset,retry %b required 000",
               {pll_reset, retry_cnt});
    end
    repeat (7) next_edge();
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++;
      $display("FAIL boundary_ready_early: got %b at E43 required 0", ready);
    end
    next_edge();
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL boundary_ready_e44: got %b required 1", ready);
    end

    pll_lock = 1'b0;
    do_reset();
    repeat (34) next_edge();
    pll_lock = 1'b1;
    repeat (2) next_edge();
    n_checks++;
    if ({pll_reset, retry_cnt} !== 3'b101) begin
      n_errors++;
      $display("FAIL boundary_late_timeout: got pll_reset,retry %b required 101",
               {pll_reset, retry_cnt});
    end
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_edge();
      n++;
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 13) begin
      n_errors++;
      $display("FAIL boundary_retry_run_latency: got %0d (seen=%0d) required 13", n, seen);
    end
    n_checks++;
    if (retry_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL boundary_retry_clear_on_run: got %0d required 0", retry_cnt);
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // Pulses E0..E3, E36..E39, E72..E75; FAIL from E108 with pll_reset held high.
  task automatic test_never_locks();
    logic       exp_rst;
    logic [1:0] exp_retry;
    logic       exp_fail;
    pll_lock = 1'b0;
    do_reset();
    for (int k = 0; k <= 115; k++) begin
      if (k > 0) next_edge();
      exp_rst   = (k <= 3) || (k >= 36 && k <= 39) || (k >= 72 && k <= 75) || (k >= 108);
      exp_retry = (k < 36) ? 2'd0 : (k < 72) ? 2'd1 : (k < 108) ? 2'd2 : 2'd3;
      exp_fail  = (k >= 108);
      n_checks++;
      if ({pll_reset, retry_cnt, fail, ready, sys_rst} !== {exp_rst, exp_retry, exp_fail, 2'b01})
      begin
        n_errors++;
        $display("FAIL never_locks_E%0d: got rst,retry,fail,ready,sys_rst %b required %b", k,
                 {pll_reset, retry_cnt, fail, ready, sys_rst},
                 {exp_rst, exp_retry, exp_fail, 2'b01});
      end
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // One reset edge (E0) then lock already high: lock_s by E2, WAIT at E4, STABLE E5, RUN E13.
  task automatic test_reset_midway(input string name);
    int n;
    bit seen;
    rst = 1'b1;
    next_edge();
    n_checks++;
    if ({pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt} !== 7'b1100000) begin
      n_errors++;
      $display("FAIL %s_outputs: got %b required %b", name,
               {pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt}, 7'b1100000);
    end
    rst = 1'b0;
    pll_lock = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_edge();
      n++;
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 13) begin
      n_errors++;
      $display("FAIL %s_restart: got %0d edges (seen=%0d) required 13", name, n, seen);
    end
  endtask

  task automatic test_reset_in_fail();
    n_checks++;
    if (fail !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_fail_precond: got fail %b required 1", fail);
    end
    pll_lock = 1'b0;
    test_reset_midway("reset_in_fail");
  endtask

  task automatic test_reset_in_run();
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_run_precond: got ready %b required 1", ready);
    end
    // Lock drops in the reset cycle too: reset must win and suppress lock_lost.
    pll_lock = 1'b0;
    test_reset_midway("reset_in_run");
  endtask

  // -------------------------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    test_reset();
    test_normal_start();
    test_flaky();
    test_loss_in_run();
    test_boundary();
    test_never_locks();
    test_reset_in_fail();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
